// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the I2C request arbiter
package i2c_arb_pkg;

  // Command field widths handed to the I2C driver
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  // Default handshake limits
  localparam int DEF_START_WAIT  = 8;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_ACT  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/i2c_arbiter_rr.sv
// rtl/i2c_arbiter_rr.sv - round-robin selector: first request above the last grant wins
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_cand;

  // Scan from farthest to nearest so the closest request after i_last overrides
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - multi-requester front end for one I2C driver; I2C_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int START_WAIT  = DEF_START_WAIT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      drv_start,
  output logic                      drv_rw,
  output logic [ADDR_W-1:0]         drv_addr,
  output logic [DATA_W-1:0]         drv_wdata,
  input  logic                      drv_busy,
  input  logic [DATA_W-1:0]         drv_rdata,
  output logic                      arb_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW_W  = $clog2(START_WAIT + 1);
  localparam logic [SW_W-1:0]  SW_LAST   = SW_W'(START_WAIT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || START_WAIT < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("i2c_arbiter: parameter out of range");
  end

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_last;
  logic [NUM_REQ-1:0]  r_owner;
  logic [NUM_REQ-1:0]  r_req_ack;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_drv_start;
  logic                r_drv_rw;
  logic [ADDR_W-1:0]   r_drv_addr;
  logic [DATA_W-1:0]   r_drv_wdata;
  logic                r_arb_busy;
  logic [SW_W-1:0]     r_wait_cnt;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_gidx;
  logic                w_any;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0]     r_to_cnt;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Transaction sequencer; every output is a register so pulses are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= LAST_INIT;
      r_owner     <= '0;
      r_req_ack   <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_drv_start <= 1'b0;
      r_drv_rw    <= 1'b0;
      r_drv_addr  <= '0;
      r_drv_wdata <= '0;
      r_arb_busy  <= 1'b0;
      r_wait_cnt  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_req_ack   <= '0;
      r_rsp_valid <= '0;
      r_drv_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A driver still busy from elsewhere blocks any new grant
          if (w_any && !drv_busy) begin
            r_req_ack   <= w_grant;
            r_owner     <= w_grant;
            r_last      <= w_gidx;
            r_drv_rw    <= req_rw[w_gidx];
            r_drv_addr  <= req_addr[w_gidx*ADDR_W +: ADDR_W];
            r_drv_wdata <= req_wdata[w_gidx*DATA_W +: DATA_W];
            r_arb_busy  <= 1'b1;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_drv_start <= 1'b1;
          r_wait_cnt  <= '0;
          r_state     <= ST_WAIT_ACT;
        end
        ST_WAIT_ACT: begin
          if (drv_busy) begin
`ifdef I2C_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            r_state  <= ST_WAIT_DONE;
          end else if (r_wait_cnt == SW_LAST) begin
            r_rsp_valid <= r_owner;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!drv_busy) begin
            r_rsp_valid <= r_owner;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= drv_rdata;
            r_state     <= ST_RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_rsp_valid <= r_owner;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          r_arb_busy <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_arb_busy <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack   = r_req_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign drv_start = r_drv_start;
  assign drv_rw    = r_drv_rw;
  assign drv_addr  = r_drv_addr;
  assign drv_wdata = r_drv_wdata;
  assign arb_busy  = r_arb_busy;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

  localparam int NR = 4;
  localparam int SW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [3:0]    req_rw = '0;
  logic [39:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_ack;
  logic [3:0]    rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          rsp_err;
  logic          drv_start;
  logic          drv_rw;
  logic [9:0]    drv_addr;
  logic [7:0]    drv_wdata;
  logic          drv_busy = 1'b0;
  logic [7:0]    drv_rdata = '0;
  logic          arb_busy;

  int checks = 0;
  int errors = 0;

  // driver model: 0 normal, 1 never acknowledges, 2 busy forced high, 3 busy forever after start
  int m_mode = 0;
  int m_len  = 20;
  int m_cnt  = 0;

  i2c_arbiter #(
    .NUM_REQ     (NR),
    .START_WAIT  (SW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .drv_start (drv_start),
    .drv_rw    (drv_rw),
    .drv_addr  (drv_addr),
    .drv_wdata (drv_wdata),
    .drv_busy  (drv_busy),
    .drv_rdata (drv_rdata),
    .arb_busy  (arb_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (m_mode)
      0, 3: begin
        if (drv_start) begin
          drv_busy <= 1'b1;
          m_cnt    <= m_len;
        end else if (drv_busy && m_mode == 0) begin
          if (m_cnt <= 1) drv_busy <= 1'b0;
          else m_cnt <= m_cnt - 1;
        end
      end
      1: drv_busy <= 1'b0;
      default: drv_busy <= 1'b1;
    endcase
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    req_rw = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output logic [3:0] ack, output int cyc);
    ack = '0;
    cyc = 0;
    while (ack == 4'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      ack = req_ack;
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid == 4'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [37:0] obs;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    obs = {req_ack, rsp_valid, rsp_rdata, rsp_err, drv_start, drv_rw, drv_addr, drv_wdata, arb_busy};
    checks++;
    if (obs !== 38'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_grant: got ack=%b busy=%b expected 0/0", req_ack, arb_busy);
    end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    logic [3:0] ack_seen;
    logic       seen_high;
    int         fall_idx;
    int         idx;
    int         cyc;
    logic [3:0] ack;
    do_reset();
    m_mode = 0;
    m_len = 20;
    req_addr[9:0] = 10'h050;
    req_wdata[7:0] = 8'hA5;
    req_addr[39:30] = 10'h3FF;
    req_wdata[31:24] = 8'h11;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0001 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL write_ack: got ack=%b busy=%b expected 0001/1", req_ack, arb_busy);
    end
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (drv_start !== 1'b1 || drv_addr !== 10'h050 || drv_wdata !== 8'hA5 || drv_rw !== 1'b0 || req_ack !== 4'b0) begin
      errors++;
      $display("FAIL write_cmd: got start=%b addr=%h wdata=%h rw=%b ack=%b expected 1/050/a5/0/0000",
               drv_start, drv_addr, drv_wdata, drv_rw, req_ack);
    end
    @(negedge clk);
    checks++;
    if (drv_start !== 1'b0) begin
      errors++;
      $display("FAIL write_start_pulse: got %b expected 0", drv_start);
    end
    ack_seen = '0;
    seen_high = 1'b0;
    fall_idx = -1;
    idx = 0;
    while (rsp_valid == 4'b0 && idx < 200) begin
      @(negedge clk);
      idx++;
      ack_seen |= req_ack;
      if (drv_busy) seen_high = 1'b1;
      else if (seen_high && fall_idx < 0) fall_idx = idx;
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || drv_addr !== 10'h050) begin
      errors++;
      $display("FAIL write_rsp: got valid=%b err=%b addr=%h expected 0001/0/050", rsp_valid, rsp_err, drv_addr);
    end
    checks++;
    if (ack_seen !== 4'b0) begin
      errors++;
      $display("FAIL write_ignore_req: got ack=%b during transaction expected 0000", ack_seen);
    end
    checks++;
    if (idx - fall_idx !== 1) begin
      errors++;
      $display("FAIL write_rsp_latency: got %0d cycles after busy fall expected 1", idx - fall_idx);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp_pulse: got valid=%b busy=%b expected 0000/0", rsp_valid, arb_busy);
    end
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b1000) begin
      errors++;
      $display("FAIL write_next_grant: got %b expected 1000", req_ack);
    end
    req_valid = '0;
    wait_rsp(cyc);
    wait_ack(ack, cyc);
  endtask

  task automatic test_fairness();
    logic [3:0] exp_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         exp_ix [5] = '{0, 1, 2, 3, 0};
    logic [3:0] ack;
    int         cyc;
    do_reset();
    m_mode = 0;
    m_len = 3;
    req_addr = {10'h303, 10'h202, 10'h101, 10'h0F0};
    req_wdata = 32'h44332211;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(ack, cyc);
      checks++;
      if (ack !== exp_oh[i]) begin
        errors++;
        $display("FAIL fair_grant_%0d: got %b expected %b", i, ack, exp_oh[i]);
      end
      if (i > 0) begin
        checks++;
        if (cyc !== 2) begin
          errors++;
          $display("FAIL fair_back_to_back_%0d: got %0d cycles expected 2", i, cyc);
        end
      end
      @(negedge clk);
      checks++;
      if (drv_addr !== req_addr[exp_ix[i]*10 +: 10]) begin
        errors++;
        $display("FAIL fair_addr_%0d: got %h expected %h", i, drv_addr, req_addr[exp_ix[i]*10 +: 10]);
      end
      wait_rsp(cyc);
      checks++;
      if (rsp_valid !== exp_oh[i]) begin
        errors++;
        $display("FAIL fair_rsp_%0d: got %b expected %b", i, rsp_valid, exp_oh[i]);
      end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [3:0] ack;
    int         cyc;
    do_reset();
    m_mode = 0;
    m_len = 5;
    req_rw = 4'b0100;
    req_addr[29:20] = 10'h2C1;
    drv_rdata = 8'h3C;
    req_valid = 4'b0100;
    wait_ack(ack, cyc);
    checks++;
    if (ack !== 4'b0100) begin
      errors++;
      $display("FAIL read_ack: got %b expected 0100", ack);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (drv_rw !== 1'b1 || drv_addr !== 10'h2C1) begin
      errors++;
      $display("FAIL read_cmd: got rw=%b addr=%h expected 1/2c1", drv_rw, drv_addr);
    end
    wait_rsp(cyc);
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL read_rsp: got valid=%b rdata=%h err=%b expected 0100/3c/0", rsp_valid, rsp_rdata, rsp_err);
    end
    req_rw = '0;
  endtask

  task automatic test_no_ack();
    logic [3:0] ack;
    int         cyc;
    int         n;
    do_reset();
    m_mode = 1;
    req_valid = 4'b0010;
    wait_ack(ack, cyc);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (drv_start !== 1'b1) begin
      errors++;
      $display("FAIL noack_start: got %b expected 1", drv_start);
    end
    n = 0;
    while (rsp_valid == 4'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== SW) begin
      errors++;
      $display("FAIL noack_latency: got %0d cycles expected %0d", n, SW);
    end
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL noack_rsp: got valid=%b err=%b expected 0010/1", rsp_valid, rsp_err);
    end
    m_mode = 0;
    @(negedge clk);
  endtask

  task automatic test_busy_in_idle();
    logic [3:0] ack;
    logic       bad;
    int         cyc;
    do_reset();
    m_mode = 2;
    m_len = 4;
    @(negedge clk);
    req_valid = 4'b0001;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (req_ack !== 4'b0 || arb_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle_hold: got grant while driver busy expected none");
    end
    m_mode = 0;
    wait_ack(ack, cyc);
    checks++;
    if (ack !== 4'b0001) begin
      errors++;
      $display("FAIL busy_idle_release: got %b expected 0001", ack);
    end
    req_valid = '0;
    wait_rsp(cyc);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle_rsp: got valid=%b err=%b expected 0001/0", rsp_valid, rsp_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  ack;
    logic [3:0]  rsp_seen;
    logic [37:0] obs;
    int          cyc;
    int          n;
    do_reset();
    m_mode = 0;
    m_len = 30;
    req_valid = 4'b0010;
    wait_ack(ack, cyc);
    req_valid = '0;
    n = 0;
    while (drv_busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    obs = {req_ack, rsp_valid, rsp_rdata, rsp_err, drv_start, drv_rw, drv_addr, drv_wdata, arb_busy};
    checks++;
    if (obs !== 38'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    rsp_seen = '0;
    repeat (40) begin
      @(negedge clk);
      rsp_seen |= rsp_valid;
    end
    checks++;
    if (rsp_seen !== 4'b0 || drv_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_rsp: got rsp=%b busy=%b expected 0000/0", rsp_seen, drv_busy);
    end
    m_len = 3;
    req_valid = 4'b0111;
    wait_ack(ack, cyc);
    checks++;
    if (ack !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_first_grant: got %b expected 0001", ack);
    end
    req_valid = '0;
    wait_rsp(cyc);
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] ack;
    int         cyc;
    int         n;
    do_reset();
    m_mode = 3;
    m_len = 2;
    drv_rdata = 8'h5A;
    req_valid = 4'b0001;
    wait_ack(ack, cyc);
    req_valid = '0;
    n = 0;
    while (drv_busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (rsp_valid == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO + 1);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL timeout_rsp: got valid=%b err=%b rdata=%h expected 0001/1/00", rsp_valid, rsp_err, rsp_rdata);
    end
    m_mode = 0;
    repeat (5) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_read();
    test_no_ack();
    test_busy_in_idle();
    test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter START_WAIT, default 8, meaning max cycles from drv_start to drv_busy high.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096, meaning watchdog limit in WAIT_DONE (used only with I2C_ARB_TIMEOUT_EN).
REQ-004 The block SHALL have port clk, input, 1, system clock; all logic on posedge clk.
REQ-005 The block SHALL have port rst, input, 1; the reset is synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, per-requester transaction request (level, held until req_ack).
REQ-007 The block SHALL have port req_rw, input, NUM_REQ, per-requester direction (0 write, 1 read).
REQ-008 The block SHALL have port req_addr, input, NUM_REQ*10, per-requester 10-bit slave address, requester i at bits [10i+9:10i].
REQ-009 The block SHALL have port req_wdata, input, NUM_REQ*8, per-requester write byte, requester i at bits [8i+7:8i].
REQ-010 The block SHALL have port req_ack, output, NUM_REQ, one-hot one-cycle pulse meaning the request is accepted and latched.
REQ-011 The block SHALL have port rsp_valid, output, NUM_REQ, one-hot one-cycle completion pulse to the owning requester.
REQ-012 The block SHALL have port rsp_rdata, output, 8, read byte, valid with rsp_valid.
REQ-013 The block SHALL have port rsp_err, output, 1, error flag, valid with rsp_valid.
REQ-014 The block SHALL have ports drv_start (output, 1), drv_rw (output, 1), drv_addr (output, 10) and drv_wdata (output, 8), the command to the I2C driver.
REQ-015 The block SHALL have ports drv_busy (input, 1) and drv_rdata (input, 8), the driver status and read data.
REQ-016 The block SHALL have port arb_busy, output, 1, high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, LAUNCH, WAIT_ACT, WAIT_DONE and RESP.
REQ-018 IDLE SHALL go to LAUNCH when any req_valid bit is high, pulsing req_ack[g] and latching rw, addr and wdata of g into drv_* registers in the same edge.
REQ-019 Grant g SHALL be round-robin: first set req_valid bit searching upward (mod NUM_REQ) from last_grant+1; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-020 LAUNCH SHALL drive drv_start=1 for exactly one cycle, then go to WAIT_ACT; drv_rw, drv_addr and drv_wdata SHALL stay stable from LAUNCH until RESP.
REQ-021 WAIT_ACT SHALL go to WAIT_DONE on drv_busy=1, or to RESP with error set if drv_busy stays 0 for START_WAIT cycles.
REQ-022 WAIT_DONE SHALL go to RESP on drv_busy=0, capturing drv_rdata into rsp_rdata on that edge.
REQ-023 RESP SHALL pulse rsp_valid[g] for one cycle with rsp_err, then return to IDLE; the earliest next grant is the cycle after RESP.
REQ-024 Minimum latency SHALL be: req_valid high at edge N gives req_ack at N+1, drv_start at N+2, and rsp_valid 1 cycle after drv_busy falls.
REQ-025 Requests arriving or dropping while not in IDLE SHALL be ignored; deassertion of req_valid[g] after req_ack SHALL NOT abort the transaction.
REQ-026 If drv_busy is already high in IDLE, the block SHALL stay in IDLE and issue no grant until it is low.

Reset
REQ-027 While rst=1 the block SHALL force state IDLE and last_grant=NUM_REQ-1, and drive 0 on req_ack, rsp_valid, rsp_rdata, rsp_err, drv_start, drv_rw, drv_addr, drv_wdata and arb_busy.
REQ-028 Reset mid-transaction SHALL drop the transaction with no rsp_valid issued.

Configuration
REQ-029 With I2C_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_DONE, and reaching TIMEOUT_CYC SHALL force RESP with rsp_err=1 and rsp_rdata=0.
REQ-030 Without I2C_ARB_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, the counter SHALL NOT exist, and rsp_err SHALL be set only by the REQ-021 condition.

Structure
REQ-031 Package i2c_arb_pkg SHALL hold the state enum typedef, address/data width constants (10, 8), and default START_WAIT/TIMEOUT_CYC.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, last grant in; one-hot grant and index out).

Verification
REQ-033 Single write: req_valid=4'b0001, addr=10'h050, wdata=8'hA5, with the driver model busy 20 cycles -> req_ack[0], drv_addr=10'h050, drv_wdata=8'hA5, rsp_valid[0] and rsp_err=0.
REQ-034 Fairness: req_valid=4'b1111 held -> grant order 0,1,2,3,0; no requester is granted twice before the others.
REQ-035 Read: req 2 with rw=1 and a model returning 8'h3C -> rsp_valid[2], rsp_rdata=8'h3C, rsp_err=0.
REQ-036 No-ack driver: drv_busy held 0 -> rsp_err=1 exactly START_WAIT cycles after WAIT_ACT entry.
REQ-037 Timeout (macro on, TIMEOUT_CYC=16): drv_busy stuck 1 -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 cycles.
REQ-038 Reset in WAIT_DONE -> all outputs 0 next cycle, no rsp_valid, and requester 0 is granted first afterwards.
